spi_txn_ctrl: RTL and testbench
===============================

# spi_txn_ctrl

Parametrised SPI transaction controller sitting between the memory-mapped control register and the SPI master. It decodes a 32-bit control word and launches single or burst SPI transfers on a selectable chip-select channel. It waits for the master's completion handshake and strobes write-back to the data and control registers. It also keeps a wrapping transaction counter and a sticky error flag for timeout or illegal-channel conditions.

## Interface
Parameters:
- CNT_W, 8: width of transaction counter `transac` (1..16).
- N_CS, 4: number of chip-select channels (1..16).
- BURST_W, 4: width of burst-length field (1..8); burst length = field + 1.
- TO_W, 10: timeout counter width; a transfer aborts after 2^TO_W cycles without done.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_data_control  in  32  control word:
  - bit0 SEND, bit1 CLR_CNT.
  - bits[11:8] channel index.
  - bits[16+BURST_W-1:16] burst length minus one.
  - Other bits ignored.
- i_spi_busy  in  1  SPI master busy (level).
- i_spi_done  in  1  one-cycle pulse: current SPI transfer finished.
- o_send  out  1  one-cycle launch pulse to SPI master.
- o_clear  out  1  one-cycle; write-back data has SEND=0.
- WR2D  out  1  one-cycle strobe: capture SPI rx data into data register.
- WR2C  out  1  one-cycle strobe: write status back to control register.
- eneable_SPI  out  1  SPI enable, high from launch until write-back.
- o_cs  out  N_CS  one-hot chip select, active-high, held during the whole burst.
- transac  out  CNT_W  completed-transaction count.
- o_err  out  1  sticky error flag.

## Operation
- All outputs are registered. Reset (any cycle, including mid-burst): state IDLE; every output 0, including transac, o_cs and o_err; internal burst and timeout counters 0.
- FSM states: IDLE, START, WAIT, WB, HOLD.
- IDLE: eneable_SPI=0, o_cs=0.
  - If SEND=1 and i_spi_busy=0: latch channel and burst length, clear o_err.
  - If CLR_CNT=1 in that same cycle, transac<=0.
  - If channel >= N_CS: set o_err, go to WB with no transfer.
  - Otherwise: o_cs<=onehot(channel), eneable_SPI<=1, go to START.
  - If SEND=1 while i_spi_busy=1: wait in IDLE.
  - CLR_CNT=1 with SEND=0 in IDLE: transac<=0, no launch.
- START: o_send=1 for exactly one cycle; timeout counter reset; go to WAIT.
- WAIT: timeout counter increments each cycle. On i_spi_done:
  - WR2D pulse; transac<=transac+1 (mod 2^CNT_W, wraps silently).
  - If remaining==0, go to WB. Otherwise remaining<=remaining-1 and go to START.
- Timeout: counter reaches 2^TO_W-1 with no done → o_err<=1, go to WB. No WR2D and no increment.
- Done has priority over timeout in the same cycle.
- WB: WR2C=1 and o_clear=1 for one cycle; eneable_SPI<=0, o_cs<=0; go to HOLD.
- HOLD: wait until SEND=0, then go to IDLE. A still-set SEND bit never relaunches.
- Changes to i_data_control after launch are ignored until the next IDLE.
- o_err is cleared only by rst or by a new launch.

## Timing
- Launch latency: SEND sampled high in IDLE at edge N → eneable_SPI and o_cs high after N, o_send high in cycle N+1.
- Done at edge M → WR2D and transac update after M.
  - Next o_send at M+1 if burst remains.
  - Otherwise WR2C/o_clear at M+1, eneable_SPI low after M+1.
- Minimum single transfer, SEND to WR2C: 3 cycles plus SPI latency.
- Burst of B transfers: exactly B o_send pulses, B WR2D pulses, 1 WR2C pulse.
- i_spi_done outside WAIT is ignored.

## Test plan
- Reset mid-burst: launch burst 4, assert rst after 2nd done → next cycle all outputs 0, state IDLE; holding SEND high relaunches only after rst drops.
- Single transfer on channel 2, N_CS=4: SEND=1, done 5 cycles after o_send →
  - one o_send, o_cs=4'b0100, one WR2D, transac 0→1.
  - WR2C+o_clear one cycle after done, then HOLD until SEND=0.
- Burst: field=3 (4 transfers), CLR_CNT=1 at launch with transac=7 → transac ends at 4; 4 o_send, 4 WR2D, 1 WR2C; o_cs stable throughout.
- Counter wrap: CNT_W=8, transac=255, single transfer → transac=0, o_err stays 0.
- Timeout: TO_W=4, never assert done → o_err=1 after 15 WAIT cycles, WR2C pulse, no WR2D, transac unchanged; next launch clears o_err.
- Illegal channel 6 with N_CS=4 → no o_send, o_cs stays 0, o_err=1, WR2C pulse. SEND with i_spi_busy=1 → no launch until busy drops.

Source files
------------

// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: decodes the control word, runs single or burst
// transfers on one chip-select channel, then strobes register write-back.
module spi_txn_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned N_CS    = 4,
    parameter int unsigned BURST_W = 4,
    parameter int unsigned TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_data_control,
    input  logic              i_spi_busy,
    input  logic              i_spi_done,
    output logic              o_send,
    output logic              o_clear,
    output logic              WR2D,
    output logic              WR2C,
    output logic              eneable_SPI,
    output logic [N_CS-1:0]   o_cs,
    output logic [CNT_W-1:0]  transac,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WB,
        S_HOLD
    } state_t;

    localparam logic [4:0]      LP_NCS    = 5'(N_CS);
    localparam logic [TO_W-1:0] LP_TO_MAX = {TO_W{1'b1}};

    state_t               r_state, w_state_nxt;
    logic                 r_send, w_send_nxt;
    logic                 r_clear, w_clear_nxt;
    logic                 r_wr2d, w_wr2d_nxt;
    logic                 r_wr2c, w_wr2c_nxt;
    logic                 r_en, w_en_nxt;
    logic [N_CS-1:0]      r_cs, w_cs_nxt;
    logic [CNT_W-1:0]     r_transac, w_transac_nxt;
    logic                 r_err, w_err_nxt;
    logic [BURST_W-1:0]   r_remain, w_remain_nxt;
    logic [TO_W-1:0]      r_to, w_to_nxt;

    logic                 w_ctl_send;
    logic                 w_ctl_clr;
    logic [3:0]           w_ctl_chan;
    logic [BURST_W-1:0]   w_ctl_blen;
    logic [N_CS-1:0]      w_onehot;
    logic [TO_W-1:0]      w_to_inc;
    logic                 w_unused;

    assign w_ctl_send = i_data_control[0];
    assign w_ctl_clr  = i_data_control[1];
    assign w_ctl_chan = i_data_control[11:8];
    assign w_ctl_blen = i_data_control[16+BURST_W-1:16];
    assign w_onehot   = N_CS'(1) << w_ctl_chan;
    assign w_to_inc   = r_to + TO_W'(1);
    assign w_unused   = ^{i_data_control[31:16+BURST_W], i_data_control[15:12],
                          i_data_control[7:2]};

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt   = r_state;
        w_send_nxt    = 1'b0;
        w_clear_nxt   = 1'b0;
        w_wr2d_nxt    = 1'b0;
        w_wr2c_nxt    = 1'b0;
        w_en_nxt      = r_en;
        w_cs_nxt      = r_cs;
        w_transac_nxt = r_transac;
        w_err_nxt     = r_err;
        w_remain_nxt  = r_remain;
        w_to_nxt      = r_to;

        unique case (r_state)
            S_IDLE: begin
                w_en_nxt = 1'b0;
                w_cs_nxt = '0;
                if (w_ctl_clr) w_transac_nxt = '0;
                if (w_ctl_send && !i_spi_busy) begin
                    w_remain_nxt = w_ctl_blen;
                    w_err_nxt    = 1'b0;
                    if ({1'b0, w_ctl_chan} >= LP_NCS) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_WB;
                    end else begin
                        w_cs_nxt    = w_onehot;
                        w_en_nxt    = 1'b1;
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                w_send_nxt  = 1'b1;
                w_to_nxt    = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done pulse wins over a timeout landing in the same cycle.
                if (i_spi_done) begin
                    w_wr2d_nxt    = 1'b1;
                    w_transac_nxt = r_transac + CNT_W'(1);
                    if (r_remain == '0) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_remain_nxt = r_remain - BURST_W'(1);
                        w_state_nxt  = S_START;
                    end
                end else if (w_to_inc == LP_TO_MAX) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WB;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end
            S_WB: begin
                w_wr2c_nxt  = 1'b1;
                w_clear_nxt = 1'b1;
                w_en_nxt    = 1'b0;
                w_cs_nxt    = '0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!w_ctl_send) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state   <= S_IDLE;
            r_send    <= 1'b0;
            r_clear   <= 1'b0;
            r_wr2d    <= 1'b0;
            r_wr2c    <= 1'b0;
            r_en      <= 1'b0;
            r_cs      <= '0;
            r_transac <= '0;
            r_err     <= 1'b0;
            r_remain  <= '0;
            r_to      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_send    <= w_send_nxt;
            r_clear   <= w_clear_nxt;
            r_wr2d    <= w_wr2d_nxt;
            r_wr2c    <= w_wr2c_nxt;
            r_en      <= w_en_nxt;
            r_cs      <= w_cs_nxt;
            r_transac <= w_transac_nxt;
            r_err     <= w_err_nxt;
            r_remain  <= w_remain_nxt;
            r_to      <= w_to_nxt;
        end
    end

    assign o_send      = r_send;
    assign o_clear     = r_clear;
    assign WR2D        = r_wr2d;
    assign WR2C        = r_wr2c;
    assign eneable_SPI = r_en;
    assign o_cs        = r_cs;
    assign transac     = r_transac;
    assign o_err       = r_err;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Self-checking bench for spi_txn_ctrl: an emulated SPI master answers each
// launch, a monitor counts strobes, and a transaction-level model predicts results.
module tb_spi_txn_ctrl;

    localparam int CNT_W   = 8;
    localparam int N_CS    = 4;
    localparam int BURST_W = 4;
    localparam int TO_W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       data_ctl;
    logic              done_r;
    logic              resp_busy;
    logic              force_busy;
    logic              busy;
    logic              o_send, o_clear, WR2D, WR2C, eneable_SPI, o_err;
    logic [N_CS-1:0]   o_cs;
    logic [CNT_W-1:0]  transac;

    assign busy = resp_busy | force_busy;

    spi_txn_ctrl #(.CNT_W(CNT_W), .N_CS(N_CS), .BURST_W(BURST_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .i_data_control(data_ctl), .i_spi_busy(busy),
        .i_spi_done(done_r), .o_send(o_send), .o_clear(o_clear), .WR2D(WR2D),
        .WR2C(WR2C), .eneable_SPI(eneable_SPI), .o_cs(o_cs), .transac(transac),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_transac = 0;

    // Emulated SPI master: answers each o_send with one done pulse.
    int resp_lat = -1;
    bit resp_en  = 1'b1;
    initial begin
        int lat;
        done_r = 1'b0;
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && o_send === 1'b1) begin
                resp_busy = 1'b1;
                lat = (resp_lat < 0) ? int'($urandom_range(0, 4)) : resp_lat;
                repeat (lat) @(negedge clk);
                done_r = 1'b1;
                @(negedge clk);
                done_r = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    // Monitor: counts strobes and remembers when they happened.
    int cyc = 0;
    int n_send = 0, n_wr2d = 0, n_wr2c = 0, n_clear = 0, n_en_rise = 0, n_cs_glitch = 0;
    int last_send_cyc = 0, last_wr2d_cyc = 0, last_wr2c_cyc = 0, en_rise_cyc = 0;
    logic            prev_en = 1'b0;
    logic [N_CS-1:0] prev_cs = '0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (o_send === 1'b1)  begin n_send++;  last_send_cyc = cyc; end
        if (WR2D === 1'b1)    begin n_wr2d++;  last_wr2d_cyc = cyc; end
        if (WR2C === 1'b1)    begin n_wr2c++;  last_wr2c_cyc = cyc; end
        if (o_clear === 1'b1) n_clear++;
        if (eneable_SPI === 1'b1 && prev_en !== 1'b1) begin n_en_rise++; en_rise_cyc = cyc; end
        if (eneable_SPI === 1'b1 && prev_en === 1'b1 && o_cs !== prev_cs) n_cs_glitch++;
        prev_en = eneable_SPI;
        prev_cs = o_cs;
    end

    function automatic logic [31:0] make_ctl(int ch, int field, bit clr, bit send);
        logic [31:0] c;
        c = $urandom;
        c[0] = send;
        c[1] = clr;
        c[11:8] = 4'(ch);
        c[19:16] = 4'(field);
        return c;
    endfunction

    task automatic wait_wr2c(input int budget, output bit ok);
        int start;
        start = n_wr2c;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_wr2c != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic release_send();
        data_ctl = make_ctl(0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        int base;
        rst = 1'b1;
        data_ctl = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_send, o_clear, WR2D, WR2C, eneable_SPI, o_cs, transac, o_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {o_send, o_clear, WR2D, WR2C, eneable_SPI, o_cs, transac, o_err});
        end
        rst = 1'b0;
        model_transac = 0;
        @(negedge clk);
        resp_lat = 2;
        base = n_wr2d;
        data_ctl = make_ctl(1, 3, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_wr2d == base + 2) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_burst_progress: got %0d done strobes expected 2", n_wr2d - base); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_send, o_clear, WR2D, WR2C, eneable_SPI, o_cs, transac, o_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_midburst_outputs: got %h expected 0",
                     {o_send, o_clear, WR2D, WR2C, eneable_SPI, o_cs, transac, o_err});
        end
        base = n_send;
        repeat (2) @(negedge clk);
        n_checks++;
        if (eneable_SPI !== 1'b0 || n_send != base) begin
            n_fail++;
            $display("FAIL reset_hold_no_launch: got en=%b sends=%0d expected en=0 sends=0", eneable_SPI, n_send - base);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (eneable_SPI !== 1'b1 || o_cs !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_relaunch: got en=%b cs=%b expected en=1 cs=0010", eneable_SPI, o_cs);
        end
        wait_wr2c(200, ok);
        model_transac = 4;
        n_checks++;
        if (!ok || transac !== CNT_W'(model_transac)) begin
            n_fail++;
            $display("FAIL reset_relaunch_result: got done=%b transac=%0d expected done=1 transac=%0d", ok, transac, model_transac);
        end
        release_send();
        resp_lat = -1;
    endtask

    task automatic test_single();
        bit ok;
        int b_send, b_wr2d, b_wr2c, b_clr;
        resp_lat = 5;
        b_send = n_send; b_wr2d = n_wr2d; b_wr2c = n_wr2c; b_clr = n_clear;
        data_ctl = make_ctl(2, 0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (eneable_SPI !== 1'b1 || o_cs !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_launch: got en=%b cs=%b expected en=1 cs=0100", eneable_SPI, o_cs);
        end
        wait_wr2c(100, ok);
        model_transac = (model_transac + 1) % (1 << CNT_W);
        n_checks++;
        if (!ok || n_send - b_send != 1 || n_wr2d - b_wr2d != 1 || n_wr2c - b_wr2c != 1 || n_clear - b_clr != 1) begin
            n_fail++;
            $display("FAIL single_counts: got send=%0d wr2d=%0d wr2c=%0d clear=%0d expected 1 each",
                     n_send - b_send, n_wr2d - b_wr2d, n_wr2c - b_wr2c, n_clear - b_clr);
        end
        n_checks++;
        if (transac !== CNT_W'(model_transac) || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_transac: got transac=%0d err=%b expected %0d err=0", transac, o_err, model_transac);
        end
        n_checks++;
        if (last_send_cyc != en_rise_cyc + 1 || last_wr2c_cyc != last_wr2d_cyc + 1) begin
            n_fail++;
            $display("FAIL single_timing: got send-en=%0d wr2c-wr2d=%0d expected 1 and 1",
                     last_send_cyc - en_rise_cyc, last_wr2c_cyc - last_wr2d_cyc);
        end
        b_send = n_send;
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_send != b_send || eneable_SPI !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: got sends=%0d en=%b expected 0 and 0", n_send - b_send, eneable_SPI);
        end
        release_send();
        resp_lat = -1;
    endtask

    task automatic test_burst();
        bit ok;
        int b_send, b_wr2d, b_wr2c, b_glitch;
        data_ctl = make_ctl(3, 6, 1'b1, 1'b1);
        wait_wr2c(200, ok);
        release_send();
        model_transac = 7;
        n_checks++;
        if (!ok || transac !== CNT_W'(model_transac)) begin
            n_fail++;
            $display("FAIL burst_preload: got transac=%0d expected %0d", transac, model_transac);
        end
        b_send = n_send; b_wr2d = n_wr2d; b_wr2c = n_wr2c; b_glitch = n_cs_glitch;
        data_ctl = make_ctl(1, 3, 1'b1, 1'b1);
        wait_wr2c(200, ok);
        model_transac = 4;
        n_checks++;
        if (!ok || transac !== CNT_W'(model_transac)) begin
            n_fail++;
            $display("FAIL burst_transac: got %0d expected %0d", transac, model_transac);
        end
        n_checks++;
        if (n_send - b_send != 4 || n_wr2d - b_wr2d != 4 || n_wr2c - b_wr2c != 1 || n_cs_glitch != b_glitch) begin
            n_fail++;
            $display("FAIL burst_counts: got send=%0d wr2d=%0d wr2c=%0d cs_changes=%0d expected 4 4 1 0",
                     n_send - b_send, n_wr2d - b_wr2d, n_wr2c - b_wr2c, n_cs_glitch - b_glitch);
        end
        release_send();
    endtask

    task automatic test_wrap();
        bit ok;
        bit all_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_ctl = make_ctl($urandom_range(0, 3), (i == 15) ? 14 : 15, i == 0, 1'b1);
            wait_wr2c(400, ok);
            all_ok &= ok;
            release_send();
        end
        model_transac = 255;
        n_checks++;
        if (!all_ok || transac !== CNT_W'(model_transac)) begin
            n_fail++;
            $display("FAIL wrap_preload: got transac=%0d expected %0d", transac, model_transac);
        end
        data_ctl = make_ctl(0, 0, 1'b0, 1'b1);
        wait_wr2c(100, ok);
        model_transac = (model_transac + 1) % (1 << CNT_W);
        n_checks++;
        if (!ok || transac !== CNT_W'(model_transac) || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_result: got transac=%0d err=%b expected %0d err=0", transac, o_err, model_transac);
        end
        release_send();
    endtask

    task automatic test_timeout();
        bit ok;
        int k, b_wr2d, b_wr2c;
        resp_en = 1'b0;
        b_wr2d = n_wr2d; b_wr2c = n_wr2c;
        data_ctl = make_ctl(0, 0, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_send === 1'b1) begin ok = 1'b1; break; end
        end
        k = 0;
        while (ok && o_err !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!ok || k != (1 << TO_W) - 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d wait cycles expected %0d", k, (1 << TO_W) - 1);
        end
        wait_wr2c(10, ok);
        n_checks++;
        if (!ok || n_wr2d != b_wr2d || n_wr2c - b_wr2c != 1 || transac !== CNT_W'(model_transac) || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_result: got wr2d=%0d wr2c=%0d transac=%0d err=%b expected 0 1 %0d 1",
                     n_wr2d - b_wr2d, n_wr2c - b_wr2c, transac, o_err, model_transac);
        end
        release_send();
        resp_en = 1'b1;
        data_ctl = make_ctl(3, 0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (o_err !== 1'b0 || o_cs !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_err_cleared: got err=%b cs=%b expected err=0 cs=1000", o_err, o_cs);
        end
        wait_wr2c(100, ok);
        model_transac = (model_transac + 1) % (1 << CNT_W);
        release_send();
    endtask

    task automatic test_illegal_and_busy();
        bit ok;
        int b_send, b_rise, b_wr2c;
        b_send = n_send; b_rise = n_en_rise; b_wr2c = n_wr2c;
        data_ctl = make_ctl(6, 2, 1'b0, 1'b1);
        wait_wr2c(20, ok);
        n_checks++;
        if (!ok || n_send != b_send || n_en_rise != b_rise || o_cs !== '0 || o_err !== 1'b1 || n_wr2c - b_wr2c != 1) begin
            n_fail++;
            $display("FAIL illegal_channel: got sends=%0d en_rises=%0d cs=%b err=%b wr2c=%0d expected 0 0 0000 1 1",
                     n_send - b_send, n_en_rise - b_rise, o_cs, o_err, n_wr2c - b_wr2c);
        end
        release_send();
        force_busy = 1'b1;
        b_send = n_send;
        data_ctl = make_ctl(1, 0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (n_send != b_send || eneable_SPI !== 1'b0 || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_blocks_launch: got sends=%0d en=%b err=%b expected 0 0 1", n_send - b_send, eneable_SPI, o_err);
        end
        force_busy = 1'b0;
        wait_wr2c(100, ok);
        model_transac = (model_transac + 1) % (1 << CNT_W);
        n_checks++;
        if (!ok || n_send - b_send != 1 || o_err !== 1'b0 || transac !== CNT_W'(model_transac)) begin
            n_fail++;
            $display("FAIL busy_release_launch: got sends=%0d err=%b transac=%0d expected 1 0 %0d",
                     n_send - b_send, o_err, transac, model_transac);
        end
        release_send();
    endtask

    task automatic test_random();
        bit ok;
        int ch, field, exp_sends, b_send, b_wr2c;
        bit clr, exp_err;
        for (int t = 0; t < 10; t++) begin
            ch = $urandom_range(0, 5);
            field = $urandom_range(0, 5);
            clr = 1'($urandom_range(0, 1));
            if (clr) model_transac = 0;
            exp_err = (ch >= N_CS);
            exp_sends = exp_err ? 0 : field + 1;
            model_transac = (model_transac + exp_sends) % (1 << CNT_W);
            b_send = n_send; b_wr2c = n_wr2c;
            data_ctl = make_ctl(ch, field, clr, 1'b1);
            wait_wr2c(20 * (field + 1) + 40, ok);
            n_checks++;
            if (!ok || transac !== CNT_W'(model_transac) || o_err !== exp_err ||
                n_send - b_send != exp_sends || n_wr2c - b_wr2c != 1) begin
                n_fail++;
                $display("FAIL random_txn%0d ch=%0d field=%0d clr=%b: got transac=%0d err=%b sends=%0d wr2c=%0d expected %0d %b %0d 1",
                         t, ch, field, clr, transac, o_err, n_send - b_send, n_wr2c - b_wr2c,
                         model_transac, exp_err, exp_sends);
            end
            release_send();
        end
    endtask

    initial begin
        force_busy = 1'b0;
        rst = 1'b1;
        data_ctl = 32'd0;
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_timeout();
        test_illegal_and_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
